ir_nec_transmitter: RTL and testbench

NEC-protocol infrared encoder, the transmit counterpart of the IR receive path that decodes IRDA_RXD into IR_button. It accepts an 8-bit address and an 8-bit command and serialises a full NEC frame, or a repeat code, onto an IR LED pin as a 38 kHz modulated signal. Uses: board-to-board command relay (drive-state forwarding) and loopback self-test of the IR receiver.

---
 rtl/ir_pkg.sv | 30 +++
 rtl/ir_carrier_gen.sv | 54 +++++
 rtl/ir_nec_transmitter.sv | 157 +++++++++++++++
 tb/tb_ir_nec_transmitter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// ir_pkg: shared NEC infrared protocol definitions.
//   - ir_state_e : frame sequencer states
//   - *_U        : segment lengths in NEC units (1 unit = 562.5 us)
//   - NEC_BITS   : payload length of a full frame
//   - is_mark()  : true for states in which the LED envelope is on
// The IR receive path uses the same constants, so the two ends of a
// link cannot drift apart.
package ir_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK
    } ir_state_e;

    localparam int LEAD_MARK_U    = 16;
    localparam int LEAD_SPACE_U   = 8;
    localparam int REPEAT_SPACE_U = 4;
    localparam int ONE_SPACE_U    = 3;
    localparam int UNIT_U         = 1;
    localparam int NEC_BITS       = 32;

    function automatic logic is_mark(input ir_state_e s);
        return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
    endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// ir_carrier_gen: square-wave carrier for IR LED modulation.
// Ports:
//   clk_50  in  system clock
//   rst_n   in  asynchronous active-low reset
//   enable  in  carrier advances while high (envelope is in a mark)
//   restart in  pulse on the cycle before a mark begins; the carrier is
//               high and freshly phased on the mark's first cycle
//   carrier out carrier level, toggles every CARRIER_HALF enabled cycles
module ir_carrier_gen
    import ir_pkg::*;
#(
    parameter int CARRIER_HALF = 658
) (
    input  logic clk_50,
    input  logic rst_n,
    input  logic enable,
    input  logic restart,
    output logic carrier
);

    localparam int CNT_W = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carrier_q, carrier_d;

    always_comb begin
        cnt_d     = cnt_q;
        carrier_d = carrier_q;
        if (restart) begin
            cnt_d     = '0;
            carrier_d = 1'b1;
        end else if (enable) begin
            if (cnt_q == CNT_W'(CARRIER_HALF - 1)) begin
                cnt_d     = '0;
                carrier_d = ~carrier_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            carrier_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            carrier_q <= carrier_d;
        end
    end

    assign carrier = carrier_q;

endmodule

// File: rtl/ir_nec_transmitter.sv
// ir_nec_transmitter: NEC infrared frame encoder.
// Serialises {~cmd, cmd, ~addr, addr} LSB first (or a repeat code) as
// pulse-distance NEC timing, optionally modulated by a carrier.
// Ports:
//   clk_50     in  system clock
//   rst_n      in  asynchronous active-low reset
//   start      in  request, sampled only in IDLE
//   repeat_req in  with start: 1 = repeat code, 0 = full frame
//   addr, cmd  in  payload bytes, latched on accepted start
//   ir_tx      out LED drive (envelope gated by carrier when MODULATE=1)
//   ir_env     out unmodulated envelope, 1 = mark
//   busy       out high while a frame is being sent
//   done       out one-cycle pulse on the cycle after the stop mark
module ir_nec_transmitter
    import ir_pkg::*;
#(
    parameter int UNIT_CYC     = 28125,
    parameter int CARRIER_HALF = 658,
    parameter int MODULATE     = 1
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic       start,
    input  logic       repeat_req,
    input  logic [7:0] addr,
    input  logic [7:0] cmd,
    output logic       ir_tx,
    output logic       ir_env,
    output logic       busy,
    output logic       done
);

    localparam int CYC_W = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;

    ir_state_e        state_q, state_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [4:0]       unit_q, unit_d;
    logic [4:0]       bit_idx_q, bit_idx_d;
    logic [31:0]      shreg_q, shreg_d;
    logic             rpt_q, rpt_d;
    logic             env_q, env_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             unit_end;
    logic             state_end;
    logic [4:0]       dur_m1;
    logic             restart;
    logic             carrier;

    // Last unit index of the current segment.
    always_comb begin
        case (state_q)
            LEAD_MARK:  dur_m1 = 5'(LEAD_MARK_U - 1);
            LEAD_SPACE: dur_m1 = rpt_q ? 5'(REPEAT_SPACE_U - 1) : 5'(LEAD_SPACE_U - 1);
            BIT_SPACE:  dur_m1 = shreg_q[0] ? 5'(ONE_SPACE_U - 1) : 5'(UNIT_U - 1);
            default:    dur_m1 = 5'(UNIT_U - 1);
        endcase
    end

    assign unit_end  = (cyc_q == CYC_W'(UNIT_CYC - 1));
    assign state_end = unit_end && (unit_q == dur_m1);

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        unit_d    = unit_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        rpt_d     = rpt_q;
        done_d    = 1'b0;

        if (state_q == IDLE) begin
            if (start) begin
                shreg_d   = {~cmd, cmd, ~addr, addr};
                rpt_d     = repeat_req;
                state_d   = LEAD_MARK;
                cyc_d     = '0;
                unit_d    = '0;
                bit_idx_d = '0;
            end
        end else begin
            if (unit_end) begin
                cyc_d  = '0;
                unit_d = unit_q + 5'd1;
            end else begin
                cyc_d = cyc_q + CYC_W'(1);
            end

            if (state_end) begin
                unit_d = '0;
                case (state_q)
                    LEAD_MARK:  state_d = LEAD_SPACE;
                    LEAD_SPACE: state_d = rpt_q ? STOP_MARK : BIT_MARK;
                    BIT_MARK:   state_d = BIT_SPACE;
                    BIT_SPACE: begin
                        shreg_d   = {1'b0, shreg_q[31:1]};
                        bit_idx_d = bit_idx_q + 5'd1;
                        state_d   = (bit_idx_q == 5'(NEC_BITS - 1)) ? STOP_MARK : BIT_MARK;
                    end
                    STOP_MARK: begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                    default:    state_d = IDLE;
                endcase
            end
        end

        busy_d = (state_d != IDLE);
        env_d  = is_mark(state_d);
    end

    // Reload the carrier phase one cycle ahead of every mark so each mark
    // opens on a carrier high half-period.
    assign restart = is_mark(state_d) && (state_d != state_q);

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cyc_q     <= '0;
            unit_q    <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            rpt_q     <= 1'b0;
            env_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            unit_q    <= unit_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            rpt_q     <= rpt_d;
            env_q     <= env_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    ir_carrier_gen #(
        .CARRIER_HALF(CARRIER_HALF)
    ) u_carrier (
        .clk_50 (clk_50),
        .rst_n  (rst_n),
        .enable (env_q),
        .restart(restart),
        .carrier(carrier)
    );

    assign ir_env = env_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign ir_tx  = (MODULATE != 0) ? (env_q & carrier) : env_q;

endmodule

// File: tb/tb_ir_nec_transmitter.sv
module tb_ir_nec_transmitter;

    localparam int U = 4;

    logic       clk_50 = 1'b0;
    logic       rst_n;
    logic       start;
    logic       repeat_req;
    logic [7:0] addr;
    logic [7:0] cmd;

    logic tx_a, env_a, busy_a, done_a;     // CARRIER_HALF=1, MODULATE=1
    logic tx_c, env_c, busy_c, done_c;     // CARRIER_HALF=3, MODULATE=1
    logic tx_m, env_m, busy_m, done_m;     // CARRIER_HALF=1, MODULATE=0

    int tests = 0;
    int fails = 0;

    // Expected per-cycle outputs: {busy,env,done,tx} for each of the three DUTs.
    logic [11:0] exp_q[$];

    // Envelope decoder and busy-length counter.
    logic        env_prev = 1'b0;
    int          low_run  = 0;
    logic [31:0] dec_word = '0;
    int          dec_cnt  = 0;
    int          busy_cnt = 0;
    int          exp_busy = 0;

    always #5 clk_50 = ~clk_50;

    ir_nec_transmitter #(.UNIT_CYC(U), .CARRIER_HALF(1), .MODULATE(1)) dut (
        .clk_50(clk_50), .rst_n(rst_n), .start(start), .repeat_req(repeat_req),
        .addr(addr), .cmd(cmd), .ir_tx(tx_a), .ir_env(env_a), .busy(busy_a), .done(done_a));

    ir_nec_transmitter #(.UNIT_CYC(U), .CARRIER_HALF(3), .MODULATE(1)) dut_c3 (
        .clk_50(clk_50), .rst_n(rst_n), .start(start), .repeat_req(repeat_req),
        .addr(addr), .cmd(cmd), .ir_tx(tx_c), .ir_env(env_c), .busy(busy_c), .done(done_c));

    ir_nec_transmitter #(.UNIT_CYC(U), .CARRIER_HALF(1), .MODULATE(0)) dut_m0 (
        .clk_50(clk_50), .rst_n(rst_n), .start(start), .repeat_req(repeat_req),
        .addr(addr), .cmd(cmd), .ir_tx(tx_m), .ir_env(env_m), .busy(busy_m), .done(done_m));

    function automatic logic [11:0] observed();
        return {busy_a, env_a, done_a, tx_a,
                busy_c, env_c, done_c, tx_c,
                busy_m, env_m, done_m, tx_m};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One segment of the reference waveform; carrier phase restarts per mark.
    task automatic push_seg(input logic mark, input int units);
        for (int i = 0; i < units * U; i++) begin
            logic t1, t3;
            t1 = mark & ((i % 2) == 0);
            t3 = mark & (((i / 3) % 2) == 0);
            exp_q.push_back({1'b1, mark, 1'b0, t1,
                             1'b1, mark, 1'b0, t3,
                             1'b1, mark, 1'b0, mark});
            exp_busy++;
        end
    endtask

    task automatic build_frame(input logic [7:0] a, input logic [7:0] c, input logic r);
        logic [31:0] w;
        w = {~c, c, ~a, a};
        exp_busy = 0;
        push_seg(1'b1, 16);
        push_seg(1'b0, r ? 4 : 8);
        if (!r) begin
            for (int b = 0; b < 32; b++) begin
                push_seg(1'b1, 1);
                push_seg(1'b0, w[b] ? 3 : 1);
            end
        end
        push_seg(1'b1, 1);
        exp_q.push_back(12'b0010_0010_0010);
    endtask

    // Advance one clock, sample #1 after the edge, compare against the model.
    task automatic cycle();
        logic [11:0] e;
        @(posedge clk_50);
        #1;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'b0;
        check("cyc_outputs", {20'b0, observed()}, {20'b0, e});
        if (busy_a) busy_cnt++;
        if (env_a && !env_prev) begin
            if (low_run == 8 * U || low_run == 4 * U) begin
                dec_word = '0;
                dec_cnt  = 0;
            end else if (low_run == U) begin
                dec_word = {1'b0, dec_word[31:1]};
                dec_cnt++;
            end else if (low_run == 3 * U) begin
                dec_word = {1'b1, dec_word[31:1]};
                dec_cnt++;
            end
            low_run = 0;
        end
        if (!env_a) low_run++;
        env_prev = env_a;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] c, input logic r);
        addr = a;
        cmd = c;
        repeat_req = r;
        start = 1'b1;
        busy_cnt = 0;
        build_frame(a, c, r);
        cycle();
        start = 1'b0;
    endtask

    task automatic run_frame();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 3000) begin
            cycle();
            n++;
        end
        check("frame_timeout", exp_q.size(), 0);
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        repeat_req = 1'b0;
        addr = 8'h00;
        cmd = 8'h00;
        #1;
        check("reset_state", {20'b0, observed()}, 32'h0);

        @(negedge clk_50);
        rst_n = 1'b1;
        run_idle(3);

        // Full frame with 16 one-bits
        send(8'h00, 8'h16, 1'b0);
        run_frame();
        check("frame_busy_len", busy_cnt, 484);
        check("frame_decode", dec_word, 32'hE916_FF00);
        check("frame_bits", dec_cnt, 32);
        run_idle(7);

        // Repeat code
        send(8'h5A, 8'h3C, 1'b1);
        run_frame();
        check("repeat_busy_len", busy_cnt, 84);
        run_idle(7);

        // Start during an active frame is ignored
        send(8'h00, 8'h16, 1'b0);
        run_idle(99);
        addr = 8'hA5;
        cmd = 8'h81;
        repeat_req = 1'b1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        addr = 8'hFF;
        cmd = 8'hFF;
        run_frame();
        check("ignored_busy_len", busy_cnt, 484);
        check("ignored_decode", dec_word, 32'hE916_FF00);
        run_idle(7);

        // Back-to-back: start on the done cycle
        send(8'h3C, 8'hC3, 1'b0);
        run_frame();
        check("b2b_first_done", {31'b0, done_a}, 32'h1);
        check("b2b_first_decode", dec_word, 32'h3CC3_C33C);
        send(8'h81, 8'h7E, 1'b0);
        check("b2b_no_gap", {31'b0, env_a}, 32'h1);
        run_frame();
        check("b2b_second_busy", busy_cnt, exp_busy);
        check("b2b_second_decode", dec_word, 32'h817E_7E81);
        run_idle(7);

        // Reset in the first bit space (addr bit0 = 1, long space)
        send(8'h01, 8'h00, 1'b0);
        run_idle(100);
        check("pre_reset_in_space", {30'b0, busy_a, env_a}, 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {20'b0, observed()}, 32'h0);
        exp_q.delete();
        @(negedge clk_50);
        rst_n = 1'b1;
        run_idle(5);
        send(8'h12, 8'h34, 1'b0);
        run_frame();
        check("post_reset_decode", dec_word, 32'hCB34_ED12);
        check("post_reset_busy", busy_cnt, exp_busy);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
